// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial WIDTH-bit unsigned subtractor (a - b), LSB first,
// one bit per clock through a single 1-bit cell built from two half-subtractor stages.
// Ports: clk, rst (async active-high); start/a/b request side (start honoured only when
//        ready=1); ready/busy/done status; diff/borrow/zero registered results that hold
//        until the next completed operation. All outputs come straight from registers.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic             borrow_ff;
  logic [CW-1:0]    cnt;

  // 1-bit subtract cell: two cascaded half-subtractors plus the borrow OR.
  logic d1, b1, dbit, b2, bout;
  logic [WIDTH-1:0] r_nxt;
  logic             last_bit;

  always_comb begin
    d1   = a_sr[0] ^ b_sr[0];
    b1   = ~a_sr[0] & b_sr[0];
    dbit = d1 ^ borrow_ff;
    b2   = ~d1 & borrow_ff;
    bout = b1 | b2;
    // Result bits enter at the MSB; after WIDTH shifts bit 0 has reached position 0.
    // Written as shifts so WIDTH=1 needs no zero-width slice.
    r_nxt    = (r_sr >> 1) | (WIDTH'(dbit) << (WIDTH - 1));
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and status outputs (status decoded from state only)
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand shifting, borrow flop, bit counter, result publish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr      <= '0;
      b_sr      <= '0;
      r_sr      <= '0;
      borrow_ff <= 1'b0;
      cnt       <= '0;
      diff      <= '0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr      <= a;
            b_sr      <= b;
            borrow_ff <= 1'b0;
            cnt       <= '0;
          end
        end
        RUN: begin
          a_sr      <= a_sr >> 1;
          b_sr      <= b_sr >> 1;
          r_sr      <= r_nxt;
          borrow_ff <= bout;
          cnt       <= cnt + CW'(1);
          // Publish on the final bit edge so results are stable throughout DONE.
          if (last_bit) begin
            diff   <= r_nxt;
            borrow <= bout;
            zero   <= (r_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
- Bit-serial WIDTH-bit subtractor controller. Computes a - b one bit per clock, LSB first, through a single shared 1-bit subtract cell.
- The cell is two cascaded half-subtractor stages plus a borrow OR; the controller owns operand shifting, the borrow flip-flop, bit counting and the start/done handshake.
- Sits between a requester and the team's half-subtractor datapath. It is the area-minimal alternative to a WIDTH-wide parallel subtractor.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request to begin a subtraction; honoured only when ready=1.
- a, input, WIDTH, minuend; sampled on the accepting edge only.
- b, input, WIDTH, subtrahend; sampled on the accepting edge only.
- ready, output, 1, high in IDLE; controller can accept start.
- busy, output, 1, high in RUN.
- done, output, 1, one-cycle pulse when the result registers update.
- diff, output, WIDTH, registered result (a - b) mod 2^WIDTH.
- borrow, output, 1, registered final borrow; 1 iff a < b (unsigned).
- zero, output, 1, registered; 1 iff diff == 0.

Behaviour:
- Reset (async, immediate, any state): state=IDLE, ready=1, busy=0, done=0, diff=0, borrow=0, zero=0.
- Reset also clears the operand shift registers, the borrow flip-flop and the bit counter.
- States:
  - IDLE: ready=1. start=1 at an edge loads a→A_sr and b→B_sr, clears borrow_ff, clears cnt, and moves to RUN.
  - RUN: busy=1. At each edge, cell inputs are A_sr[0], B_sr[0] and borrow_ff.
    - Stage 1: d1 = A0^B0; b1 = ~A0&B0.
    - Stage 2: dbit = d1^borrow_ff; b2 = ~d1&borrow_ff.
    - Updates: borrow_ff <= b1|b2; dbit shifts into the MSB of R_sr; A_sr and B_sr shift right; cnt++.
    - When cnt == WIDTH-1 at the edge (last bit), go to DONE. On that same edge, load diff <= final R_sr contents, borrow <= b1|b2, and zero <= (final diff == 0).
  - DONE: done=1 for exactly one cycle, ready=0, busy=0. Next edge always goes to IDLE.
- Latency: if start is accepted at edge t, done is high in the cycle after edge t+WIDTH. Throughput is one operation per WIDTH+2 cycles. Back-to-back start is accepted on the first IDLE edge after DONE.
- start while RUN or DONE is ignored. Operands and state are unaffected, and the request is not queued.
- a and b may change freely after the accepting edge without effect.
- diff, borrow and zero hold their value until the next DONE. They do not change during RUN.
- Counter width is clog2(WIDTH+1). With WIDTH=1, RUN lasts exactly one edge.
- Arithmetic is unsigned modulo 2^WIDTH. The borrow out of the MSB is the only overflow indication.
- Reset during RUN aborts the operation. The partial result is never published, and done does not pulse.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst=1 mid-cycle with no clock edge → all outputs at reset values immediately. Release → ready=1.
- WIDTH=8, a=200, b=55, start pulse → done pulses exactly 9 cycles after the accepting edge (WIDTH edges of RUN, then DONE); diff=145, borrow=0, zero=0, ready=1 the following cycle.
- WIDTH=8, a=5, b=9 → diff=252, borrow=1, zero=0. Then a=0x5A, b=0x5A → diff=0, borrow=0, zero=1.
- Start held high continuously with a=3, b=1, and operands changed to a=0, b=7 during RUN → first result diff=2, borrow=0. Second op accepted only after DONE, giving diff=249, borrow=1. No op is lost or duplicated.
- Assert rst after bit 4 of a=100, b=20 → no done pulse, diff stays 0, ready=1. A fresh op a=100, b=20 then yields diff=80.
- WIDTH=1, all four {a,b} combinations → (diff,borrow) = 00→(0,0), 01→(1,1), 10→(1,0), 11→(0,0). done follows each start after 1 edge.
